// File: rtl/arb_grant_rr.sv
// arb_grant_rr: round-robin grant generator feeding a one-hot source-select arbiter.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   req          - per-source level request
//   done         - consumer completion pulse for the current grant
//   n_mult_en    - registered one-hot (or zero) grant vector
//   grant_valid  - registered, high when n_mult_en is nonzero
//   grant_idx    - index of the granted source; keeps the last value when idle
//   timeout      - sticky flag, set when a grant is force-released by the hold limit
module arb_grant_rr #(
  parameter int SOURCES  = 4,
  parameter int MAX_HOLD = 0,
  parameter int IDX_W    = (SOURCES > 1) ? $clog2(SOURCES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SOURCES-1:0] req,
  input  logic               done,
  output logic [SOURCES-1:0] n_mult_en,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               timeout
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  localparam logic [15:0] HOLD_LAST = 16'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] nxt;
  logic [15:0]      hold_cnt;
  logic             hit;
  logic             rel;
  int               k;
  // Scan from the farthest offset down so the source closest to ptr wins last.
  always_comb begin
    win = ptr;
    k = 0;
    for (int i = SOURCES - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= SOURCES) k = k - SOURCES;
      if (req[IDX_W'(k)]) win = IDX_W'(k);
    end
  end
  assign hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign rel = done || !req[grant_idx] || hit;
  assign nxt = (grant_idx == IDX_W'(SOURCES - 1)) ? '0 : grant_idx + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      n_mult_en   <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      ptr         <= '0;
      hold_cnt    <= '0;
      timeout     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          state       <= GRANT;
          n_mult_en   <= SOURCES'(1) << win;
          grant_valid <= 1'b1;
          grant_idx   <= win;
          hold_cnt    <= '0;
        end
        GRANT: if (rel) begin
          state       <= GAP;
          n_mult_en   <= '0;
          grant_valid <= 1'b0;
          ptr         <= nxt;
          timeout     <= timeout | hit;
        end else begin
          hold_cnt <= hold_cnt + 16'(hold_cnt != 16'hffff);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
